if_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter, issues word fetches to a synchronous instruction memory, and buffers returned words in a small queue. It presents `{pc_4, instruction}` to the IF/ID pipeline register, stalls when that register does not advance, and refetches from a new target on a branch or jump redirect.

---
 rtl/mips_if_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 63 ++++++
 rtl/if_fetch.sv | 120 ++++++++++++
 tb/tb_if_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Holds the fetch-queue entry layout and PC arithmetic helpers.
package mips_if_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc_4;
        logic [INSTR_W-1:0] instruction;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

    // Wraps modulo 4096, so 12'hFFC + 4 yields 12'h000.
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] addr);
        return addr + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; head is read straight
// from the storage flops so it carries no path from the push data.
module fetch_queue
    import mips_if_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_entry,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, issue credit, redirect/discard and fetch queue.
// Define IF_FETCH_STATS_EN to add the redirect_cnt / stall_cnt counters.
module if_fetch
    import mips_if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'h000,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_rvalid,
`ifdef IF_FETCH_STATS_EN
    output logic [15:0]        redirect_cnt,
    output logic [15:0]        stall_cnt,
`endif
    output logic               valid,
    output logic [PC_W-1:0]    pc_4,
    output logic [INSTR_W-1:0] instruction
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  req_addr_q;
    logic             inflight;
    logic             discard;
    logic             pop;
    logic             push;
    logic             issue;
    logic             still_inflight;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   used;
    fetch_entry_t     head;
    fetch_entry_t     resp_entry;

    assign valid = (q_count != '0);
    assign pop   = go & valid;

    // Credit covers both queued words and the word still on its way back.
    assign used  = {1'b0, q_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    // rst_n gates the request so it drops the moment reset is asserted.
    assign issue = rst_n & !redirect & (used < (CNT_W+1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign push = imem_rvalid & inflight & !discard & !redirect;
    assign still_inflight = inflight & !imem_rvalid;

    always_comb begin
        resp_entry             = '0;
        resp_entry.pc_4        = pc_plus4(req_addr_q);
        resp_entry.instruction = imem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            req_addr_q <= RESET_PC;
            inflight   <= 1'b0;
            discard    <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= word_align(redirect_pc);
            end else if (issue) begin
                fetch_pc <= pc_plus4(fetch_pc);
            end
            if (issue) begin
                req_addr_q <= fetch_pc;
            end
            inflight <= issue | still_inflight;
            // A response landing in the redirect cycle is already dropped by
            // the push gate; only a word still outstanding needs discarding.
            if (redirect) begin
                discard <= still_inflight;
            end else if (imem_rvalid) begin
                discard <= 1'b0;
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_entry(resp_entry),
        .head      (head),
        .count     (q_count)
    );

    assign pc_4        = valid ? head.pc_4 : '0;
    assign instruction = valid ? head.instruction : NOP;

`ifdef IF_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (redirect && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
            if (valid && !go && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, reset sequences,
// then a randomized run against an instruction-stream reference model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        go = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = 12'h000;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_rvalid = 1'b0;
    logic        valid;
    logic [11:0] pc_4;
    logic [31:0] instruction;
`ifdef IF_FETCH_STATS_EN
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    if_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
`ifdef IF_FETCH_STATS_EN
        .redirect_cnt(redirect_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .valid       (valid),
        .pc_4        (pc_4),
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    // Instruction memory returns the byte address as the data word.
    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= {20'h0, imem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        go;
        logic        rd;
        logic [11:0] rpc;
        logic        v;
        logic [11:0] pc4;
        logic [31:0] ins;
        logic        req;
        logic [11:0] addr;
    } vec_t;

    vec_t vec [23];

    task automatic set_vec(input int i, input logic g, input logic r, input logic [11:0] rp,
                           input logic v, input logic [11:0] p4, input logic [31:0] ins,
                           input logic rq, input logic [11:0] ad);
        vec[i] = '{g, r, rp, v, p4, ins, rq, ad};
    endtask

    // Called at posedge+1: drive, sample at negedge, return at next posedge+1.
    task automatic apply_vec(input int i);
        go          = vec[i].go;
        redirect    = vec[i].rd;
        redirect_pc = vec[i].rpc;
        @(negedge clk);
        chk($sformatf("vec%0d valid", i), 32'(valid), 32'(vec[i].v));
        chk($sformatf("vec%0d instruction", i), instruction, vec[i].ins);
        if (vec[i].v) chk($sformatf("vec%0d pc_4", i), 32'(pc_4), 32'(vec[i].pc4));
        chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vec[i].req));
        if (vec[i].req) chk($sformatf("vec%0d imem_addr", i), 32'(imem_addr), 32'(vec[i].addr));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " valid"}, 32'(valid), 32'h0);
        chk({tag, " pc_4"}, 32'(pc_4), 32'h0);
        chk({tag, " instruction"}, instruction, 32'h0);
        chk({tag, " imem_req"}, 32'(imem_req), 32'h0);
        chk({tag, " imem_addr"}, 32'(imem_addr), 32'h0);
    endtask

    int          ready_at;
    int          n_red;
    int          n_stall;
    logic [11:0] stream;
    logic [11:0] fexp;
    logic [11:0] tgt;
    logic        prev_v, prev_go, prev_rd;
    logic [11:0] prev_pc4;
    logic [31:0] prev_ins;

    initial begin
        //          go rd rpc     v  pc4     ins            req addr
        set_vec( 0, 1, 0, 12'h0,  0, 12'h0,   32'h0,         1, 12'h000);
        set_vec( 1, 1, 0, 12'h0,  0, 12'h0,   32'h0,         1, 12'h004);
        set_vec( 2, 1, 0, 12'h0,  1, 12'h004, 32'h000,       1, 12'h008);
        set_vec( 3, 1, 0, 12'h0,  1, 12'h008, 32'h004,       1, 12'h00C);
        set_vec( 4, 1, 0, 12'h0,  1, 12'h00C, 32'h008,       1, 12'h010);
        set_vec( 5, 0, 0, 12'h0,  1, 12'h010, 32'h00C,       0, 12'h000);
        set_vec( 6, 0, 0, 12'h0,  1, 12'h010, 32'h00C,       0, 12'h000);
        set_vec( 7, 0, 0, 12'h0,  1, 12'h010, 32'h00C,       0, 12'h000);
        set_vec( 8, 0, 0, 12'h0,  1, 12'h010, 32'h00C,       0, 12'h000);
        set_vec( 9, 0, 0, 12'h0,  1, 12'h010, 32'h00C,       0, 12'h000);
        set_vec(10, 1, 0, 12'h0,  1, 12'h010, 32'h00C,       1, 12'h014);
        set_vec(11, 1, 1, 12'h100,1, 12'h014, 32'h010,       0, 12'h000);
        set_vec(12, 1, 0, 12'h0,  0, 12'h0,   32'h0,         1, 12'h100);
        set_vec(13, 1, 0, 12'h0,  0, 12'h0,   32'h0,         1, 12'h104);
        set_vec(14, 1, 0, 12'h0,  1, 12'h104, 32'h100,       1, 12'h108);
        set_vec(15, 1, 1, 12'hFFE,1, 12'h108, 32'h104,       0, 12'h000);
        set_vec(16, 1, 0, 12'h0,  0, 12'h0,   32'h0,         1, 12'hFFC);
        set_vec(17, 1, 0, 12'h0,  0, 12'h0,   32'h0,         1, 12'h000);
        set_vec(18, 1, 0, 12'h0,  1, 12'h000, 32'hFFC,       1, 12'h004);
        set_vec(19, 1, 0, 12'h0,  1, 12'h004, 32'h000,       1, 12'h008);
        set_vec(20, 1, 0, 12'h0,  1, 12'h008, 32'h004,       1, 12'h00C);
        set_vec(21, 1, 0, 12'h0,  1, 12'h00C, 32'h008,       1, 12'h010);
        set_vec(22, 1, 0, 12'h0,  1, 12'h010, 32'h00C,       1, 12'h014);

        // Power-on reset, checked while still asserted.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 23; i++) apply_vec(i);

        // Asynchronous reset in the middle of a burst.
        go = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) apply_vec(i);

        // Randomized run against a program-order stream model.
        rst_n = 1'b0;
        go = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_at = 2;
        stream = 12'h000;
        fexp = 12'h000;
        prev_v = 1'b0;
        prev_go = 1'b0;
        prev_rd = 1'b0;
        prev_pc4 = 12'h0;
        prev_ins = 32'h0;
        n_red = 0;
        n_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            go          = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = 12'($urandom_range(0, 4095));
            @(negedge clk);
            chk($sformatf("rnd%0d valid", c), 32'(valid), 32'(c >= ready_at));
            if (!valid) chk($sformatf("rnd%0d nop", c), instruction, 32'h0);
            if (valid && go) begin
                chk($sformatf("rnd%0d pc_4", c), 32'(pc_4), 32'(12'(stream + 12'd4)));
                chk($sformatf("rnd%0d instruction", c), instruction, {20'h0, stream});
                stream = stream + 12'd4;
            end
            if (prev_v && !prev_go && !prev_rd) begin
                chk($sformatf("rnd%0d hold pc_4", c), 32'(pc_4), 32'(prev_pc4));
                chk($sformatf("rnd%0d hold instruction", c), instruction, prev_ins);
            end
            if (redirect) begin
                chk($sformatf("rnd%0d req_on_redirect", c), 32'(imem_req), 32'h0);
                tgt = redirect_pc & 12'hFFC;
                stream = tgt;
                fexp = tgt;
                ready_at = c + 3;
                n_red++;
            end else begin
                if (!valid || go) chk($sformatf("rnd%0d req_credit", c), 32'(imem_req), 32'h1);
                if (imem_req) begin
                    chk($sformatf("rnd%0d imem_addr", c), 32'(imem_addr), 32'(fexp));
                    fexp = fexp + 12'd4;
                end
            end
            if (valid && !go) n_stall++;
            prev_v = valid;
            prev_go = go;
            prev_rd = redirect;
            prev_pc4 = pc_4;
            prev_ins = instruction;
            @(posedge clk);
            #1;
        end
        go = 1'b1;
        redirect = 1'b0;
`ifdef IF_FETCH_STATS_EN
        @(negedge clk);
        chk("redirect_cnt", 32'(redirect_cnt), 32'(n_red));
        chk("stall_cnt", 32'(stall_cnt), 32'(n_stall));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
